pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Program-counter and fetch-redirect controller for the RISC pipeline: owns the 32-bit PC and boots it from a reset vector in instruction memory. Each cycle it advances the PC sequentially by 1 or 2 words and consumes the jump unit's `taken`/`target` redirect. On a redirect it loads the target and drives a timed flush to the younger pipeline registers. It sits in the IF stage, on the receiving end of the branch-resolution interface.

## Interface
- `RESET_ADDR`, 32'h0000_0000: word address of the reset vector. `M[RESET_ADDR]` holds the high half and `M[RESET_ADDR+1]` holds the low half.
- `FLUSH_CYCLES`, 2: number of cycles `flush` stays high after an accepted redirect. Legal range is 1–7.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hazard unit request to freeze the PC.
- `taken`  in  1: branch-taken from the jump control unit.
- `target`  in  32: redirect address; zero-extended Rdst from the jump unit.
- `wide`  in  1: the instruction at `pc` is two words long (immediate form), so the sequential step is +2.
- `imem_data`  in  16: instruction-memory word at address `pc`, available in the same cycle (combinational read).
- `pc`  out  32: current fetch address, registered.
- `flush`  out  1: kill IF/ID and ID/EX contents, registered.
- `valid`  out  1: word at `pc` is a real instruction to latch into IF/ID, registered.

## Operation
- States are BOOT_HI, BOOT_LO, RUN and FLUSH. A 3-bit down-counter `fcnt` times the flush.
- Reset (`rst`=1 at an edge): state=BOOT_HI, `pc`=RESET_ADDR, `flush`=0, `valid`=0, `fcnt`=0. Reset overrides every other input in every state, including mid-boot and mid-flush.
- BOOT_HI:
  - Latch `imem_data` into `vec_hi`.
  - `pc` ← RESET_ADDR+1; go to BOOT_LO.
  - `stall`, `taken` and `wide` are ignored.
- BOOT_LO:
  - `pc` ← {`vec_hi`, `imem_data`}; `valid` ← 1; go to RUN.
  - Inputs are ignored as in BOOT_HI.
- RUN:
  - If `taken`=1: `pc` ← `target`, `flush` ← 1, `fcnt` ← FLUSH_CYCLES−1, go to FLUSH. `taken` has priority over `stall`.
  - Else if `stall`=1: hold `pc`.
  - Else: `pc` ← `pc` + (`wide` ? 2 : 1).
- FLUSH:
  - `taken` is ignored, because the instructions producing it are being killed.
  - `pc` follows the same stall/sequential rule as RUN, fetching from the target onward.
  - If `fcnt`=0: `flush` ← 0; go to RUN.
  - Else: `fcnt` ← `fcnt`−1.
- `valid` is 1 in RUN and FLUSH and 0 in both boot states. `valid` does not drop on `stall`; the hazard unit gates the IF/ID enable itself.
- Arithmetic is modulo 2^32; `pc` wraps from 0xFFFF_FFFF to 0x0000_0000 (+1) or 0x0000_0001 (+2) with no flag.
- `target` is taken verbatim, with no alignment check.
- `wide` is sampled only when a sequential step is actually taken.

## Timing
- Boot takes two cycles after reset deassertion:
  - Edge 1 (in BOOT_HI): `pc`=RESET_ADDR+1.
  - Edge 2 (in BOOT_LO): `pc`=vector and `valid`=1.
- Redirect latency is 1 cycle: `taken` sampled at edge N gives `pc`=`target` after edge N.
- `flush` is high for exactly FLUSH_CYCLES cycles, from after edge N through after edge N+FLUSH_CYCLES−1.
- A second `taken` is accepted no earlier than the cycle in which state is RUN again.
- `stall` during FLUSH freezes `pc` but does not extend `flush`, since `fcnt` counts unconditionally.
- No combinational path from any input to any output.

## Test plan
- **Boot:** M[0]=16'h0000, M[1]=16'h0040, `rst` pulsed for 1 cycle.
  - Required: `pc` = 0, then 1, then 0x0000_0040.
  - `valid` is 0, 0, then 1; `flush` stays 0 throughout.
- **Sequential step:** from `pc`=0x40 with `wide`=0,1,0 and `stall`=0,0,1.
  - Required: `pc` = 0x41, 0x43, 0x43.
- **Redirect over stall:** in RUN, `taken`=1, `target`=0x0000_0100, `stall`=1 in the same cycle.
  - Required: next `pc`=0x100.
  - `flush`=1 for exactly 2 cycles (default FLUSH_CYCLES); then `pc` continues at 0x101 and 0x102 with `stall`=0.
- **Taken ignored in FLUSH:** assert `taken` with `target`=0x200 during the first flush cycle.
  - Required: `pc` is not 0x200; flush length is unchanged.
  - A `taken` applied after return to RUN is accepted.
- **Wrap:** `target`=0xFFFF_FFFF, then a `wide`=1 step.
  - Required: `pc`=0x0000_0001 with no other side effect.
- **Reset mid-flush:** assert `rst` in the second FLUSH cycle.
  - Required: next cycle `pc`=RESET_ADDR, `flush`=0, `valid`=0, state BOOT_HI.
  - The full boot sequence then repeats.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus of the IF-stage PC controller: hazard/jump inputs, instruction word in,
// registered fetch address and pipeline control out.
interface pc_fetch_ctrl_if;
  logic        stall;
  logic        taken;
  logic [31:0] target;
  logic        wide;
  logic [15:0] imem_data;
  logic [31:0] pc;
  logic        flush;
  logic        valid;

  modport master (
    output stall, taken, target, wide, imem_data,
    input  pc, flush, valid
  );

  modport slave (
    input  stall, taken, target, wide, imem_data,
    output pc, flush, valid
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch-redirect controller: boots the PC from a two-word reset vector,
// steps it by 1 or 2 words, and turns an accepted branch redirect into a timed flush.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {BOOT_HI, BOOT_LO, RUN, FLUSH} state_t;

  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      r_state, w_stateNext;
  logic [31:0] r_pc, w_pcNext, w_seqPc;
  logic [15:0] r_vecHi, w_vecHiNext;
  logic [2:0]  r_fcnt, w_fcntNext;
  logic        r_flush, w_flushNext;
  logic        r_valid, w_validNext;

  // Shared by RUN and FLUSH; wide only matters when the step is actually taken.
  assign w_seqPc = bus.stall ? r_pc : (r_pc + (bus.wide ? 32'd2 : 32'd1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= BOOT_HI;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      BOOT_HI: w_stateNext = BOOT_LO;
      BOOT_LO: w_stateNext = RUN;
      RUN:     if (bus.taken) w_stateNext = FLUSH;
      FLUSH:   if (r_fcnt == 3'd0) w_stateNext = RUN;
    endcase
  end

  always_comb begin
    w_pcNext    = r_pc;
    w_vecHiNext = r_vecHi;
    w_fcntNext  = r_fcnt;
    w_flushNext = r_flush;
    w_validNext = r_valid;
    unique case (r_state)
      BOOT_HI: begin
        w_vecHiNext = bus.imem_data;
        w_pcNext    = RESET_ADDR + 32'd1;
        w_validNext = 1'b0;
        w_flushNext = 1'b0;
      end
      BOOT_LO: begin
        w_pcNext    = {r_vecHi, bus.imem_data};
        w_validNext = 1'b1;
      end
      RUN: begin
        w_validNext = 1'b1;
        if (bus.taken) begin
          w_pcNext    = bus.target;
          w_flushNext = 1'b1;
          w_fcntNext  = FCNT_INIT;
        end else begin
          w_pcNext    = w_seqPc;
        end
      end
      FLUSH: begin
        // taken is ignored here: the instructions that produced it are being killed.
        w_validNext = 1'b1;
        w_pcNext    = w_seqPc;
        if (r_fcnt == 3'd0) w_flushNext = 1'b0;
        else                w_fcntNext  = r_fcnt - 3'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_ADDR;
      r_vecHi <= 16'h0000;
      r_fcnt  <= 3'd0;
      r_flush <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_pc    <= w_pcNext;
      r_vecHi <= w_vecHiNext;
      r_fcnt  <= w_fcntNext;
      r_flush <= w_flushNext;
      r_valid <= w_validNext;
    end
  end

  assign bus.pc    = r_pc;
  assign bus.flush = r_flush;
  assign bus.valid = r_valid;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed boot/step/redirect/wrap/reset steps,
// then randomized traffic, all compared against a cycle-level behavioural model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_ADDR   = 32'h0000_0000;
  localparam int          FLUSH_CYCLES = 2;

  logic clk;
  logic rst;
  logic [15:0] memHi;
  logic [15:0] memLo;

  int checks;
  int errors;

  // Model state: boot progress, remaining flush cycles, expected outputs.
  logic [31:0] mPc;
  logic [15:0] mVecHi;
  int          mBootStep;
  int          mFlushLeft;
  logic        mValid;

  pc_fetch_ctrl_if ifc ();

  pc_fetch_ctrl #(
    .RESET_ADDR   (RESET_ADDR),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: the two vector words, anything else is address-derived filler.
  assign ifc.imem_data = (ifc.pc == RESET_ADDR)         ? memHi :
                         (ifc.pc == RESET_ADDR + 32'd1) ? memLo :
                                                          (ifc.pc[15:0] ^ 16'h5A5A);

  function automatic logic [15:0] memWord(input logic [31:0] a);
    if (a == RESET_ADDR)              return memHi;
    else if (a == RESET_ADDR + 32'd1) return memLo;
    else                              return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic checkOutput(input string tag);
    checks++;
    assert (ifc.pc === mPc) else begin
      errors++;
      $error("[TB] FAIL %s pc observed=%h expected=%h", tag, ifc.pc, mPc);
    end
    checks++;
    assert (ifc.flush === (mFlushLeft > 0)) else begin
      errors++;
      $error("[TB] FAIL %s flush observed=%b expected=%b", tag, ifc.flush, (mFlushLeft > 0));
    end
    checks++;
    assert (ifc.valid === mValid) else begin
      errors++;
      $error("[TB] FAIL %s valid observed=%b expected=%b", tag, ifc.valid, mValid);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge, then check.
  task automatic applyStimulus(input string tag, input logic rstV, input logic stallV,
                               input logic takenV, input logic [31:0] tgt, input logic wideV);
    rst        = rstV;
    ifc.stall  = stallV;
    ifc.taken  = takenV;
    ifc.target = tgt;
    ifc.wide   = wideV;
    if (rstV) begin
      mPc        = RESET_ADDR;
      mBootStep  = 0;
      mFlushLeft = 0;
      mValid     = 1'b0;
    end else if (mBootStep == 0) begin
      mVecHi    = memWord(mPc);
      mPc       = RESET_ADDR + 32'd1;
      mBootStep = 1;
    end else if (mBootStep == 1) begin
      mPc       = {mVecHi, memWord(mPc)};
      mValid    = 1'b1;
      mBootStep = 2;
    end else if (takenV && mFlushLeft == 0) begin
      mPc        = tgt;
      mFlushLeft = FLUSH_CYCLES;
    end else begin
      if (!stallV) mPc = mPc + (wideV ? 32'd2 : 32'd1);
      if (mFlushLeft > 0) mFlushLeft--;
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    mPc        = RESET_ADDR;
    mVecHi     = 16'h0000;
    mBootStep  = 0;
    mFlushLeft = 0;
    mValid     = 1'b0;
    memHi      = 16'h0000;
    memLo      = 16'h0040;

    applyStimulus("reset",         1, 0, 0, 32'h0,         0);
    applyStimulus("boot_hi",       0, 1, 1, 32'h0000_0999, 1);
    applyStimulus("boot_lo",       0, 1, 1, 32'h0000_0999, 1);
    applyStimulus("step_narrow",   0, 0, 0, 32'h0,         0);
    applyStimulus("step_wide",     0, 0, 0, 32'h0,         1);
    applyStimulus("step_stall",    0, 1, 0, 32'h0,         1);
    applyStimulus("redir_stall",   0, 1, 1, 32'h0000_0100, 0);
    applyStimulus("flush1_taken",  0, 0, 1, 32'h0000_0200, 0);
    applyStimulus("flush2",        0, 0, 0, 32'h0,         0);
    applyStimulus("rerun_taken",   0, 0, 1, 32'h0000_0300, 0);
    applyStimulus("after_300_a",   0, 0, 0, 32'h0,         0);
    applyStimulus("after_300_b",   0, 0, 0, 32'h0,         0);
    applyStimulus("wrap_target",   0, 0, 1, 32'hFFFF_FFFF, 0);
    applyStimulus("wrap_wide",     0, 0, 0, 32'h0,         1);
    applyStimulus("wrap_next",     0, 0, 0, 32'h0,         0);
    applyStimulus("mid_redirect",  0, 0, 1, 32'h0000_0500, 0);
    applyStimulus("mid_flush1",    0, 0, 0, 32'h0,         0);
    memHi = 16'h1234;
    memLo = 16'h5678;
    applyStimulus("mid_reset",     1, 0, 1, 32'h0000_0777, 1);
    applyStimulus("reboot_hi",     0, 0, 0, 32'h0,         0);
    applyStimulus("reboot_lo",     0, 0, 0, 32'h0,         0);

    for (int i = 0; i < 400; i++) begin
      logic rV, sV, tV, wV;
      logic [31:0] tgt;
      rV  = ($urandom_range(0, 99) < 2);
      sV  = ($urandom_range(0, 99) < 30);
      tV  = ($urandom_range(0, 99) < 15);
      wV  = $urandom_range(0, 1) == 1;
      tgt = $urandom;
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFFF - 32'($urandom_range(0, 1));
      if (rV) begin
        memHi = 16'($urandom);
        memLo = 16'($urandom);
      end
      applyStimulus("random", rV, sV, tV, tgt, wV);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
